// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_pkg
// Desc     : Shared mode encodings, constants and bit-field expansion helper
//            for the Vdp colour output path.
// Revision : 1.0  initial release
// ============================================================================
package video_pkg;

    typedef enum logic [1:0] {
        MODE_RGB332 = 2'd0,
        MODE_PAL    = 2'd1,
        MODE_GRAY   = 2'd2,
        MODE_RSVD   = 2'd3
    } video_mode_e;

    localparam logic [3:0] BRIGHT_FULL = 4'd15;
    localparam int         PIPE_LAT    = 3;
    localparam int         EXP_MAX_W   = 32;
    localparam int         EXP_IDX_W   = $clog2(EXP_MAX_W);

    // Widen an n-bit field to w bits by repeating it MSB-first; bits above w are zero.
    function automatic logic [EXP_MAX_W-1:0] expand(input logic [7:0] field,
                                                    input int         n,
                                                    input int         w);
        logic [EXP_MAX_W-1:0] res;
        res = '0;
        for (int i = 0; i < EXP_MAX_W; i++) begin
            if (i < w) begin
                res[EXP_IDX_W'(w - 1 - i)] = field[3'(n - 1 - (i % n))];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_palette_ram.sv
`default_nettype none
// ============================================================================
// Module   : video_palette_ram
// Desc     : Palette storage, one write port and one registered read port;
//            a same-cycle write/read of one address returns the old entry.
// Revision : 1.0  initial release
// ============================================================================
module video_palette_ram #(
    parameter  int ENTRIES = 16,
    parameter  int DATA_W  = 24,
    localparam int ADDR_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem_q [ENTRIES];
    logic [DATA_W-1:0] r_rdata_q;

    // Contents are deliberately not reset so software-loaded palettes survive.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_waddr] <= i_wdata;
        end
        r_rdata_q <= r_mem_q[i_raddr];
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/video_color_out.sv
`default_nettype none
// ============================================================================
// Module   : video_color_out
// Desc     : Vdp pixel output stage: RGB332 / palette / gray decode, per-frame
//            brightness fade, blanking and matching 3-cycle sync delay.
// Revision : 1.0  initial release
// ============================================================================
module video_color_out
    import video_pkg::*;
#(
    parameter  int CH_W        = 8,
    parameter  int PAL_ENTRIES = 16,
    localparam int IDX_W       = $clog2(PAL_ENTRIES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        pix_in,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [1:0]        mode_req,
    input  logic [3:0]        bright_req,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_addr,
    input  logic [3*CH_W-1:0] pal_data,
    output logic              hsync,
    output logic              vsync,
    output logic [4*CH_W-1:0] rgb
);

    localparam logic [CH_W-1:0] c_alpha = '1;

    // Frame latch
    video_mode_e       r_act_mode_q,   w_act_mode_d;
    logic [3:0]        r_act_bright_q, w_act_bright_d;
    logic              r_vs_prev_q,    w_vs_prev_d;
    logic              w_vs_rise;

    // S1
    logic [7:0]        r_s1_pix_q,     w_s1_pix_d;
    logic              r_s1_de_q,      w_s1_de_d;
    logic              r_s1_hs_q,      w_s1_hs_d;
    logic              r_s1_vs_q,      w_s1_vs_d;
    video_mode_e       r_s1_mode_q,    w_s1_mode_d;
    logic [3:0]        r_s1_bright_q,  w_s1_bright_d;

    // S2
    logic [3*CH_W-1:0] r_s2_color_q,   w_s2_color_d;
    logic              r_s2_use_pal_q, w_s2_use_pal_d;
    logic              r_s2_de_q,      w_s2_de_d;
    logic              r_s2_hs_q,      w_s2_hs_d;
    logic              r_s2_vs_q,      w_s2_vs_d;
    logic [3:0]        r_s2_bright_q,  w_s2_bright_d;

    // S3
    logic [4*CH_W-1:0] r_rgb_q,        w_rgb_d;
    logic              r_s3_hs_q,      w_s3_hs_d;
    logic              r_s3_vs_q,      w_s3_vs_d;

    logic [CH_W-1:0]   w_exp_r, w_exp_g, w_exp_b, w_exp_y;
    logic [3*CH_W-1:0] w_pal_rdata;
    logic [3*CH_W-1:0] w_src;
    logic [4:0]        w_bright_p1;
    logic [CH_W-1:0]   w_scaled [3];

    video_palette_ram #(
        .ENTRIES (PAL_ENTRIES),
        .DATA_W  (3*CH_W)
    ) u_palette (
        .clk     (clk),
        .i_we    (pal_we),
        .i_waddr (pal_addr),
        .i_wdata (pal_data),
        .i_raddr (r_s1_pix_q[IDX_W-1:0]),
        .o_rdata (w_pal_rdata)
    );

    assign w_src       = r_s2_use_pal_q ? w_pal_rdata : r_s2_color_q;
    assign w_bright_p1 = {1'b0, r_s2_bright_q} + 5'd1;

    // (c * (bright+1)) >> 4 in CH_W+4 bits; bright=15 is an exact passthrough.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign w_scaled[gi] = CH_W'(((CH_W+4)'(w_src[gi*CH_W +: CH_W]) *
                                     (CH_W+4)'(w_bright_p1)) >> 4);
    end

    always_comb begin
        // Mode/brightness only move on the cycle after a registered vsync rise.
        w_vs_rise      = r_s1_vs_q & ~r_vs_prev_q;
        w_vs_prev_d    = r_s1_vs_q;
        w_act_mode_d   = r_act_mode_q;
        w_act_bright_d = r_act_bright_q;
        if (w_vs_rise) begin
            w_act_mode_d   = (video_mode_e'(mode_req) == MODE_RSVD) ? MODE_RGB332
                                                                    : video_mode_e'(mode_req);
            w_act_bright_d = bright_req;
        end

        w_s1_pix_d     = pix_in;
        w_s1_de_d      = de_in;
        w_s1_hs_d      = hsync_in;
        w_s1_vs_d      = vsync_in;
        w_s1_mode_d    = w_act_mode_d;
        w_s1_bright_d  = w_act_bright_d;

        w_exp_r = CH_W'(expand({5'd0, r_s1_pix_q[7:5]}, 3, CH_W));
        w_exp_g = CH_W'(expand({5'd0, r_s1_pix_q[4:2]}, 3, CH_W));
        w_exp_b = CH_W'(expand({6'd0, r_s1_pix_q[1:0]}, 2, CH_W));
        w_exp_y = CH_W'(expand(r_s1_pix_q, 8, CH_W));
        case (r_s1_mode_q)
            MODE_GRAY: w_s2_color_d = {w_exp_y, w_exp_y, w_exp_y};
            default:   w_s2_color_d = {w_exp_b, w_exp_g, w_exp_r};
        endcase
        w_s2_use_pal_d = (r_s1_mode_q == MODE_PAL);
        w_s2_de_d      = r_s1_de_q;
        w_s2_hs_d      = r_s1_hs_q;
        w_s2_vs_d      = r_s1_vs_q;
        w_s2_bright_d  = r_s1_bright_q;

        w_rgb_d = {c_alpha, {(3*CH_W){1'b0}}};
        if (r_s2_de_q) begin
            w_rgb_d = {c_alpha, w_scaled[2], w_scaled[1], w_scaled[0]};
        end
        w_s3_hs_d = r_s2_hs_q;
        w_s3_vs_d = r_s2_vs_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_act_mode_q   <= MODE_RGB332;
            r_act_bright_q <= BRIGHT_FULL;
            r_vs_prev_q    <= 1'b0;
            r_s1_pix_q     <= '0;
            r_s1_de_q      <= 1'b0;
            r_s1_hs_q      <= 1'b0;
            r_s1_vs_q      <= 1'b0;
            r_s1_mode_q    <= MODE_RGB332;
            r_s1_bright_q  <= BRIGHT_FULL;
            r_s2_color_q   <= '0;
            r_s2_use_pal_q <= 1'b0;
            r_s2_de_q      <= 1'b0;
            r_s2_hs_q      <= 1'b0;
            r_s2_vs_q      <= 1'b0;
            r_s2_bright_q  <= BRIGHT_FULL;
            r_rgb_q        <= {c_alpha, {(3*CH_W){1'b0}}};
            r_s3_hs_q      <= 1'b0;
            r_s3_vs_q      <= 1'b0;
        end else begin
            r_act_mode_q   <= w_act_mode_d;
            r_act_bright_q <= w_act_bright_d;
            r_vs_prev_q    <= w_vs_prev_d;
            r_s1_pix_q     <= w_s1_pix_d;
            r_s1_de_q      <= w_s1_de_d;
            r_s1_hs_q      <= w_s1_hs_d;
            r_s1_vs_q      <= w_s1_vs_d;
            r_s1_mode_q    <= w_s1_mode_d;
            r_s1_bright_q  <= w_s1_bright_d;
            r_s2_color_q   <= w_s2_color_d;
            r_s2_use_pal_q <= w_s2_use_pal_d;
            r_s2_de_q      <= w_s2_de_d;
            r_s2_hs_q      <= w_s2_hs_d;
            r_s2_vs_q      <= w_s2_vs_d;
            r_s2_bright_q  <= w_s2_bright_d;
            r_rgb_q        <= w_rgb_d;
            r_s3_hs_q      <= w_s3_hs_d;
            r_s3_vs_q      <= w_s3_vs_d;
        end
    end

    assign rgb   = r_rgb_q;
    assign hsync = r_s3_hs_q;
    assign vsync = r_s3_vs_q;

endmodule
`default_nettype wire

// File: tb/tb_video_color_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_color_out
// Desc     : Directed and randomized bench for video_color_out with a
//            behavioural per-pixel reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_video_color_out;

    localparam int          CH_W  = 8;
    localparam int          PAL_N = 16;
    localparam int          RGB_W = 4 * CH_W;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = video_pkg::PIPE_LAT;
    localparam logic [31:0] BLANK = 32'hFF000000;

    logic        clk;
    logic        reset;
    logic [7:0]  pix_in;
    logic        de_in, hsync_in, vsync_in;
    logic [1:0]  mode_req;
    logic [3:0]  bright_req;
    logic        pal_we;
    logic [3:0]  pal_addr;
    logic [23:0] pal_data;
    logic        hsync, vsync;
    logic [RGB_W-1:0] rgb;

    int n_total;
    int n_bad;
    int cyc;

    // Reference model state
    logic [23:0] pal_m [PAL_N];
    int          m_mode;
    int          m_bright;
    logic        m_vs1, m_vs2;
    logic [31:0] exp_rgb [DEPTH];
    logic        exp_hs  [DEPTH];
    logic        exp_vs  [DEPTH];

    video_color_out #(.CH_W(CH_W), .PAL_ENTRIES(PAL_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .de_in      (de_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .mode_req   (mode_req),
        .bright_req (bright_req),
        .pal_we     (pal_we),
        .pal_addr   (pal_addr),
        .pal_data   (pal_data),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Repeat the field until it covers CH_W bits, then keep the top CH_W bits.
    function automatic int unsigned m_expand(input int unsigned f, input int n);
        longint unsigned rep;
        int bits;
        rep  = 0;
        bits = 0;
        while (bits < CH_W) begin
            rep  = (rep << n) | longint'(f);
            bits = bits + n;
        end
        return int'(rep >> (bits - CH_W));
    endfunction

    function automatic logic [31:0] model_pixel(input logic [7:0] p, input logic de);
        int unsigned ch [3];
        logic [23:0] ent;
        logic [3:0]  idx;
        if (!de) return BLANK;
        idx = p[3:0];
        case (m_mode)
            1: begin
                ent   = pal_m[idx];
                ch[0] = ent[7:0];
                ch[1] = ent[15:8];
                ch[2] = ent[23:16];
            end
            2: begin
                ch[0] = m_expand(p, 8);
                ch[1] = ch[0];
                ch[2] = ch[0];
            end
            default: begin
                ch[0] = m_expand(p >> 5, 3);
                ch[1] = m_expand((p >> 2) & 8'h7, 3);
                ch[2] = m_expand(p & 8'h3, 2);
            end
        endcase
        for (int c = 0; c < 3; c++) ch[c] = (ch[c] * (m_bright + 1)) / 16;
        return {8'hFF, 8'(ch[2]), 8'(ch[1]), 8'(ch[0])};
    endfunction

    always @(posedge clk) begin
        if (pal_we) pal_m[pal_addr] = pal_data;
        if (cyc < DEPTH) begin
            if (!reset) begin
                m_vs1    = 1'b0;
                m_vs2    = 1'b0;
                m_mode   = 0;
                m_bright = 15;
                for (int j = 0; j < LAT; j++) begin
                    if (cyc - j >= 0) begin
                        exp_rgb[cyc-j] = BLANK;
                        exp_hs[cyc-j]  = 1'b0;
                        exp_vs[cyc-j]  = 1'b0;
                    end
                end
            end else begin
                if (m_vs1 && !m_vs2) begin
                    m_mode   = (mode_req == 2'd3) ? 0 : int'(mode_req);
                    m_bright = int'(bright_req);
                end
                exp_rgb[cyc] = model_pixel(pix_in, de_in);
                exp_hs[cyc]  = hsync_in;
                exp_vs[cyc]  = vsync_in;
                m_vs2 = m_vs1;
                m_vs1 = vsync_in;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cyc >= LAT && cyc < DEPTH) begin
            chk_val("pipe_rgb", rgb, exp_rgb[cyc-LAT]);
            chk_val("pipe_hsync", {31'd0, hsync}, {31'd0, exp_hs[cyc-LAT]});
            chk_val("pipe_vsync", {31'd0, vsync}, {31'd0, exp_vs[cyc-LAT]});
        end
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        n_total = 0; n_bad = 0; cyc = 0;
        m_mode = 0; m_bright = 15; m_vs1 = 1'b0; m_vs2 = 1'b0;
        for (int i = 0; i < PAL_N; i++) pal_m[i] = 24'h0;
        reset = 1'b0; pix_in = 8'h00; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        mode_req = 2'd0; bright_req = 4'd15; pal_we = 1'b0; pal_addr = 4'd0; pal_data = 24'h0;

        repeat (2) @(negedge clk);
        chk_val("reset_rgb", rgb, BLANK);
        chk_val("reset_hsync", {31'd0, hsync}, 32'd0);
        chk_val("reset_vsync", {31'd0, vsync}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < PAL_N; i++) begin
            pal_we = 1'b1; pal_addr = 4'(i); pal_data = 24'($urandom);
            @(negedge clk);
        end
        pal_we = 1'b0;

        de_in = 1'b1; pix_in = 8'hE0;
        repeat (LAT) @(negedge clk);
        chk_val("rgb332_red", rgb, 32'hFF0000FF);
        pix_in = 8'h03;
        repeat (LAT) @(negedge clk);
        chk_val("rgb332_blue", rgb, 32'hFFFF0000);

        mode_req = 2'd1; vsync_in = 1'b1;
        @(negedge clk);
        vsync_in = 1'b0;
        repeat (2) @(negedge clk);
        pal_we = 1'b1; pal_addr = 4'd5; pal_data = 24'h123456;
        @(negedge clk);
        pal_we = 1'b0; pix_in = 8'h05;
        repeat (LAT) @(negedge clk);
        chk_val("pal_read", rgb, 32'hFF123456);
        pal_we = 1'b1; pal_addr = 4'd5; pal_data = 24'hABCDEF;
        @(negedge clk);
        pal_we = 1'b0;
        @(negedge clk);
        chk_val("pal_collide_old", rgb, 32'hFF123456);
        @(negedge clk);
        chk_val("pal_collide_new", rgb, 32'hFFABCDEF);

        mode_req = 2'd2; bright_req = 4'd7; vsync_in = 1'b1;
        @(negedge clk);
        vsync_in = 1'b0; pix_in = 8'h80;
        repeat (LAT) @(negedge clk);
        chk_val("gray_dim", rgb, 32'hFF404040);
        bright_req = 4'd15;
        repeat (4) @(negedge clk);
        chk_val("bright_hold", rgb, 32'hFF404040);
        vsync_in = 1'b1;
        @(negedge clk);
        vsync_in = 1'b0;
        repeat (LAT) @(negedge clk);
        chk_val("bright_new", rgb, 32'hFF808080);

        de_in = 1'b0; pix_in = 8'hFF;
        repeat (LAT) @(negedge clk);
        chk_val("blank", rgb, BLANK);
        hsync_in = 1'b1; vsync_in = 1'b1;
        @(negedge clk);
        hsync_in = 1'b0; vsync_in = 1'b0;
        chk_val("sync_d1", {30'd0, hsync, vsync}, 32'd0);
        @(negedge clk);
        chk_val("sync_d2", {30'd0, hsync, vsync}, 32'd0);
        @(negedge clk);
        chk_val("sync_d3", {30'd0, hsync, vsync}, 32'd3);
        chk_val("sync_rgb", rgb, BLANK);
        @(negedge clk);
        chk_val("sync_d4", {30'd0, hsync, vsync}, 32'd0);

        de_in = 1'b1; pix_in = 8'h80; mode_req = 2'd2; bright_req = 4'd3;
        reset = 1'b0;
        @(negedge clk);
        chk_val("rst_mid", rgb, BLANK);
        reset = 1'b1; pix_in = 8'hE0;
        repeat (LAT) @(negedge clk);
        chk_val("rst_mode_default", rgb, 32'hFF0000FF);

        for (int k = 0; k < 2000; k++) begin
            reset      = ($urandom_range(0, 299) != 0);
            pix_in     = 8'($urandom);
            de_in      = ($urandom_range(0, 7) != 0);
            hsync_in   = ($urandom_range(0, 15) == 0);
            vsync_in   = ($urandom_range(0, 39) == 0);
            mode_req   = 2'($urandom);
            bright_req = 4'($urandom);
            pal_we     = ($urandom_range(0, 3) == 0);
            pal_addr   = 4'($urandom);
            pal_data   = 24'($urandom);
            @(negedge clk);
        end
        reset = 1'b1; pal_we = 1'b0; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        repeat (LAT + 1) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
